// File: rtl/usart_pkg.sv
// Shared types and constants for the USART receive frame controller.
// Holds the FSM state encoding and the inter-byte timeout calculation.
package usart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    PAYLOAD,
    CHECK,
    DELIVER
  } state_t;

  localparam logic [7:0]  DEFAULT_SOF_BYTE = 8'hA5;
  localparam int unsigned BITS_PER_BYTE    = 10;

  // 64-bit intermediate: bytes * bits * clk_freq overflows 32 bits at common clock rates.
  function automatic int unsigned timeout_clks(
    input longint unsigned clk_freq,
    input longint unsigned baud_rate,
    input longint unsigned timeout_bytes
  );
    longint unsigned clks;
    clks = (timeout_bytes * 64'(BITS_PER_BYTE) * clk_freq) / baud_rate;
    return 32'(clks);
  endfunction

endpackage

// File: rtl/usart_frame_mem.sv
// Payload buffer: DEPTH x 8 register file, synchronous write, combinational read.
// Contents are not reset; only bytes already written are ever read back.
module usart_frame_mem #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/usart_rx_frame_ctrl.sv
// Frame parser behind the USART receiver: SOF, LEN, payload, XOR checksum.
// Good frames are buffered and replayed on a valid/ready byte stream.
module usart_rx_frame_ctrl
  import usart_pkg::*;
#(
  parameter int unsigned CLK_FREQ      = 100_000_000,
  parameter int unsigned BAUD_RATE     = 115_200,
  parameter logic [7:0]  SOF_BYTE      = DEFAULT_SOF_BYTE,
  parameter int unsigned MAX_LEN       = 16,
  parameter int unsigned TIMEOUT_BYTES = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_enable,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_last,
  input  logic        out_ready,
  output logic        frame_ok,
  output logic        err_checksum,
  output logic        err_length,
  output logic        err_timeout,
  output logic        err_overrun,
  output logic [15:0] frame_count
);

  localparam int unsigned TIMEOUT_CLKS =
    timeout_clks(64'(CLK_FREQ), 64'(BAUD_RATE), 64'(TIMEOUT_BYTES));
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam int IW = $clog2(MAX_LEN + 1);
  localparam int MW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CLKS - 1);

  state_t          state_q, state_d;
  logic            en_q, primed_q;
  logic [IW-1:0]   len_q, len_d, idx_q, idx_d, rd_idx_q, rd_idx_d;
  logic [7:0]      csum_q, csum_d;
  logic [TW-1:0]   t_q, t_d;
  logic [15:0]     frame_count_q, frame_count_d;
  logic            frame_ok_d, err_checksum_d, err_length_d, err_timeout_d, err_overrun_d;
  logic            byte_valid, mem_we, handshake, last_rd, timed;
  logic [7:0]      mem_rd;

  assign byte_valid  = primed_q & (rx_enable ^ en_q);
  assign out_valid   = (state_q == DELIVER);
  assign last_rd     = (rd_idx_q == len_q - IW'(1));
  assign out_last    = out_valid & last_rd;
  assign out_data    = out_valid ? mem_rd : 8'h00;
  assign handshake   = out_valid & out_ready;
  assign mem_we      = (state_q == PAYLOAD) & byte_valid;
  assign timed       = (state_q == LEN) | (state_q == PAYLOAD) | (state_q == CHECK);
  assign frame_count = frame_count_q;

  usart_frame_mem #(
    .DEPTH (MAX_LEN),
    .AW    (MW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (mem_we),
    .wr_addr (idx_q[MW-1:0]),
    .wr_data (rx_data),
    .rd_addr (rd_idx_q[MW-1:0]),
    .rd_data (mem_rd)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      en_q          <= 1'b0;
      primed_q      <= 1'b0;
      len_q         <= '0;
      idx_q         <= '0;
      rd_idx_q      <= '0;
      csum_q        <= '0;
      t_q           <= '0;
      frame_count_q <= '0;
      frame_ok      <= 1'b0;
      err_checksum  <= 1'b0;
      err_length    <= 1'b0;
      err_timeout   <= 1'b0;
      err_overrun   <= 1'b0;
    end else begin
      state_q       <= state_d;
      en_q          <= rx_enable;
      primed_q      <= 1'b1;
      len_q         <= len_d;
      idx_q         <= idx_d;
      rd_idx_q      <= rd_idx_d;
      csum_q        <= csum_d;
      t_q           <= t_d;
      frame_count_q <= frame_count_d;
      frame_ok      <= frame_ok_d;
      err_checksum  <= err_checksum_d;
      err_length    <= err_length_d;
      err_timeout   <= err_timeout_d;
      err_overrun   <= err_overrun_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    len_d          = len_q;
    idx_d          = idx_q;
    rd_idx_d       = rd_idx_q;
    csum_d         = csum_q;
    t_d            = '0;
    frame_count_d  = frame_count_q;
    frame_ok_d     = 1'b0;
    err_checksum_d = 1'b0;
    err_length_d   = 1'b0;
    err_timeout_d  = 1'b0;
    err_overrun_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (byte_valid && rx_data == SOF_BYTE) state_d = LEN;
      end
      LEN: begin
        if (byte_valid) begin
          if (rx_data == 8'h00 || rx_data > 8'(MAX_LEN)) begin
            err_length_d = 1'b1;
            state_d      = IDLE;
          end else begin
            len_d   = IW'(rx_data);
            csum_d  = rx_data;
            idx_d   = '0;
            state_d = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (byte_valid) begin
          csum_d = csum_q ^ rx_data;
          idx_d  = idx_q + IW'(1);
          if (idx_q == len_q - IW'(1)) state_d = CHECK;
        end
      end
      CHECK: begin
        if (byte_valid) begin
          if (rx_data == csum_q) begin
            frame_ok_d    = 1'b1;
            frame_count_d = frame_count_q + 16'd1;
            rd_idx_d      = '0;
            state_d       = DELIVER;
          end else begin
            err_checksum_d = 1'b1;
            state_d        = IDLE;
          end
        end
      end
      DELIVER: begin
        // The buffer is busy replaying; anything arriving now is lost.
        if (byte_valid) err_overrun_d = 1'b1;
        if (handshake) begin
          if (last_rd) state_d = IDLE;
          else         rd_idx_d = rd_idx_q + IW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // A byte in the expiry cycle clears the counter instead of timing out.
    if (timed && !byte_valid) begin
      if (t_q == T_LAST) begin
        err_timeout_d = 1'b1;
        state_d       = IDLE;
      end else begin
        t_d = t_q + TW'(1);
      end
    end
  end

endmodule
